// File: rtl/core_mem_responder.sv
// Word RAM with an INIT/LOAD/RUN front end for the core's instr and data ports.
// Define MEM_WRFWD_EN to forward same-cycle data writes to the instr port.
module core_mem_responder #(
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 512,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic [31:0]       instr_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              wen0_i,
  input  logic [3:0]        wmask0_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic              load_valid_i,
  input  logic [31:0]       load_data_i,
  output logic              load_ready_o,
  input  logic              load_done_i,
  output logic              mem_ready_o
);

  localparam int IW = ADDR_W - 2;

  typedef enum logic [1:0] {
    INIT,
    LOAD,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] clear_ptr_q;
  logic [IW-1:0] load_ptr_q;
  logic [31:0]   mem [DEPTH];

  logic          we;
  logic [3:0]    wbe;
  logic [IW-1:0] widx;
  logic [31:0]   wdata;
  logic [31:0]   instr_rd;

  logic [IW-1:0] iidx;
  logic [IW-1:0] didx;
  logic          beat;
  logic          unused_addr_bits;

  assign iidx = instr_addr_i[ADDR_W-1:2];
  assign didx = data_addr_i[ADDR_W-1:2];
  assign beat = load_valid_i & load_ready_o;
  assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (clear_ptr_q == IW'(DEPTH-1)) state_d = LOAD;
      LOAD:    if (load_done_i) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // One shared write port: clear in INIT, loader in LOAD, core stores in RUN.
  always_comb begin
    load_ready_o = 1'b0;
    mem_ready_o  = 1'b0;
    we           = 1'b0;
    wbe          = 4'hF;
    widx         = '0;
    wdata        = '0;
    unique case (state_q)
      INIT: begin
        we   = 1'b1;
        widx = clear_ptr_q;
      end
      LOAD: begin
        load_ready_o = 1'b1;
        we           = load_valid_i;
        widx         = load_ptr_q;
        wdata        = load_data_i;
      end
      RUN: begin
        mem_ready_o = 1'b1;
        we          = ~wen0_i;
        widx        = didx;
        wdata       = data_i;
        wbe         = wmask0_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clear_ptr_q <= '0;
      load_ptr_q  <= IW'(LOAD_BASE);
    end else begin
      if (state_q == INIT) clear_ptr_q <= clear_ptr_q + 1'b1;
      if (beat)            load_ptr_q  <= load_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we && !reset_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wbe[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

`ifdef MEM_WRFWD_EN
  always_comb begin
    instr_rd = mem[iidx];
    if (!wen0_i && (iidx == didx)) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask0_i[k]) instr_rd[8*k +: 8] = data_i[8*k +: 8];
      end
    end
  end
`else
  assign instr_rd = mem[iidx];
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i || state_q != RUN) begin
      instr_o <= '0;
      data_o  <= '0;
    end else begin
      instr_o <= instr_rd;
      data_o  <= mem[didx];
    end
  end

endmodule
